pe_ws_dbuf: RTL and testbench

Parametrised weight-stationary systolic MAC processing element with a double-buffered (shadow/active) weight store. It is the next generation of the single-weight PE and tiles into the same row/column array. Activations flow left-to-right, partial sums top-to-bottom, and weights shift down a column chain. A column can preload the next weight tile into the shadow registers while the current tile computes, then commit it with a single swap pulse, so weight loading no longer stalls compute.

---
 rtl/pe_pkg.sv | 49 ++++
 rtl/pe_wbuf.sv | 76 +++++++
 rtl/pe_ws_dbuf.sv | 103 ++++++++++
 tb/tb_pe_ws_dbuf.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the weight-stationary PE family.
//   - default ACT_W / WGT_W / ACC_W
//   - ACC_MAX / ACC_MIN for the default accumulator width
//   - sat_add(): signed add with overflow detect and optional clamp
package pe_pkg;

    localparam int ACT_W_DEF = 8;
    localparam int WGT_W_DEF = 8;
    localparam int ACC_W_DEF = 32;

    // Width of the internal add. Any accumulator up to MAX_W-1 bits
    // fits without the add itself overflowing.
    localparam int MAX_W = 64;

    localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

    typedef struct packed {
        logic signed [MAX_W-1:0] sum;
        logic                    ovf;
    } sat_add_t;

    // Adds two sign-extended operands and checks the result against an
    // acc_w-bit signed range. With sat_en the sum is clamped; otherwise
    // the caller truncates to acc_w bits, which gives two's-complement wrap.
    function automatic sat_add_t sat_add(
        input logic signed [MAX_W-1:0] a,
        input logic signed [MAX_W-1:0] b,
        input int                      acc_w,
        input logic                    sat_en
    );
        sat_add_t                r;
        logic signed [MAX_W-1:0] full;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        hi    = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (acc_w - 1));
        full  = a + b;
        r.ovf = (full > hi) || (full < lo);
        r.sum = full;
        if (sat_en && (full > hi)) begin
            r.sum = hi;
        end else if (sat_en && (full < lo)) begin
            r.sum = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_wbuf.sv
// pe_wbuf: double-buffered weight store for one PE.
//   CLK, RESET (async, active-low), en (global enable)
//   w_in / w_valid_in   : weight chain input and shift strobe
//   w_swap_in           : commit shadow -> active
//   w_out / w_valid_out : weight chain output to the PE below
//   w_swap_out          : w_swap_in delayed one cycle
//   active / active_vld : committed weight used by the MAC
module pe_wbuf
    import pe_pkg::*;
#(
    parameter int WGT_W = WGT_W_DEF
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    en,
    input  logic signed [WGT_W-1:0] w_in,
    input  logic                    w_valid_in,
    input  logic                    w_swap_in,
    output logic signed [WGT_W-1:0] w_out,
    output logic                    w_valid_out,
    output logic                    w_swap_out,
    output logic signed [WGT_W-1:0] active,
    output logic                    active_vld
);

    logic signed [WGT_W-1:0] shadow_reg;
    logic                    shadow_vld_reg;
    logic signed [WGT_W-1:0] active_reg;
    logic                    active_vld_reg;
    logic signed [WGT_W-1:0] w_out_reg;
    logic                    w_valid_out_reg;
    logic                    w_swap_out_reg;

    logic commit;
    logic shadow_vld_next;

    // An empty shadow makes the swap a no-op for active.
    assign commit = w_swap_in & shadow_vld_reg;

    // A shift in the same cycle as a commit refills the shadow, so the
    // load wins over the clear.
    assign shadow_vld_next = w_valid_in | (shadow_vld_reg & ~w_swap_in);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            shadow_reg      <= '0;
            shadow_vld_reg  <= 1'b0;
            active_reg      <= '0;
            active_vld_reg  <= 1'b0;
            w_out_reg       <= '0;
            w_valid_out_reg <= 1'b0;
            w_swap_out_reg  <= 1'b0;
        end else if (en) begin
            if (w_valid_in) begin
                shadow_reg      <= w_in;
                w_out_reg       <= shadow_reg;
                w_valid_out_reg <= shadow_vld_reg;
            end else begin
                w_valid_out_reg <= 1'b0;
            end
            if (commit) begin
                active_reg     <= shadow_reg;
                active_vld_reg <= 1'b1;
            end
            shadow_vld_reg <= shadow_vld_next;
            w_swap_out_reg <= w_swap_in;
        end
    end

    assign w_out       = w_out_reg;
    assign w_valid_out = w_valid_out_reg;
    assign w_swap_out  = w_swap_out_reg;
    assign active      = active_reg;
    assign active_vld  = active_vld_reg;

endmodule

// File: rtl/pe_ws_dbuf.sv
// pe_ws_dbuf: weight-stationary systolic MAC PE with shadow/active weights.
//   CLK, RESET (async, active-low), EN (global enable, low = hold)
//   act_in/act_valid_in   -> act_out/act_valid_out   (1-cycle pass-through)
//   psum_in               -> psum_out/psum_valid_out (psum_in + act*active)
//   w_in/w_valid_in/w_swap_in -> w_out/w_valid_out/w_swap_out (weight chain)
//   ovf : sticky accumulate-overflow flag
// ACC_W must be >= ACT_W+WGT_W and below pe_pkg::MAX_W.
module pe_ws_dbuf
    import pe_pkg::*;
#(
    parameter int ACT_W  = ACT_W_DEF,
    parameter int WGT_W  = WGT_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter bit SAT_EN = 1'b0
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    EN,
    input  logic signed [ACT_W-1:0] act_in,
    input  logic                    act_valid_in,
    output logic signed [ACT_W-1:0] act_out,
    output logic                    act_valid_out,
    input  logic signed [ACC_W-1:0] psum_in,
    output logic signed [ACC_W-1:0] psum_out,
    output logic                    psum_valid_out,
    input  logic signed [WGT_W-1:0] w_in,
    input  logic                    w_valid_in,
    output logic signed [WGT_W-1:0] w_out,
    output logic                    w_valid_out,
    input  logic                    w_swap_in,
    output logic                    w_swap_out,
    output logic                    ovf
);

    localparam int PROD_W = ACT_W + WGT_W;

    logic signed [WGT_W-1:0]  active;
    logic                     active_vld;
    logic signed [PROD_W-1:0] prod;
    logic signed [MAX_W-1:0]  prod_ext;
    logic signed [MAX_W-1:0]  psum_ext;
    sat_add_t                 mac_res;
    logic signed [ACC_W-1:0]  psum_next;

    logic signed [ACT_W-1:0]  act_out_reg;
    logic                     act_valid_out_reg;
    logic signed [ACC_W-1:0]  psum_out_reg;
    logic                     psum_valid_out_reg;
    logic                     ovf_reg;

    pe_wbuf #(
        .WGT_W (WGT_W)
    ) u_wbuf (
        .CLK         (CLK),
        .RESET       (RESET),
        .en          (EN),
        .w_in        (w_in),
        .w_valid_in  (w_valid_in),
        .w_swap_in   (w_swap_in),
        .w_out       (w_out),
        .w_valid_out (w_valid_out),
        .w_swap_out  (w_swap_out),
        .active      (active),
        .active_vld  (active_vld)
    );

    // Full-width signed product; the registered active weight is read
    // here, so a swap in this cycle only affects the next MAC.
    assign prod     = PROD_W'(act_in) * PROD_W'(active);
    assign prod_ext = active_vld ? MAX_W'(prod) : '0;
    assign psum_ext = MAX_W'(psum_in);
    assign mac_res  = sat_add(psum_ext, prod_ext, ACC_W, SAT_EN);
    // Truncation is the wrap case; in saturating mode the sum is already
    // clamped into range so truncation is lossless.
    assign psum_next = mac_res.sum[ACC_W-1:0];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            act_out_reg        <= '0;
            act_valid_out_reg  <= 1'b0;
            psum_out_reg       <= '0;
            psum_valid_out_reg <= 1'b0;
            ovf_reg            <= 1'b0;
        end else if (EN) begin
            act_out_reg        <= act_in;
            act_valid_out_reg  <= act_valid_in;
            psum_valid_out_reg <= act_valid_in;
            if (act_valid_in) begin
                psum_out_reg <= psum_next;
                if (mac_res.ovf) begin
                    ovf_reg <= 1'b1;
                end
            end
        end
    end

    assign act_out        = act_out_reg;
    assign act_valid_out  = act_valid_out_reg;
    assign psum_out       = psum_out_reg;
    assign psum_valid_out = psum_valid_out_reg;
    assign ovf            = ovf_reg;

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Directed bench for pe_ws_dbuf: one saturating and one wrapping instance
// share all inputs.
module tb_pe_ws_dbuf;

    logic               CLK;
    logic               RESET;
    logic               EN;
    logic signed [7:0]  act_in;
    logic               act_valid_in;
    logic signed [31:0] psum_in;
    logic signed [7:0]  w_in;
    logic               w_valid_in;
    logic               w_swap_in;

    logic signed [7:0]  s_act_out, r_act_out;
    logic               s_act_valid_out, r_act_valid_out;
    logic signed [31:0] s_psum_out, r_psum_out;
    logic               s_psum_valid_out, r_psum_valid_out;
    logic signed [7:0]  s_w_out, r_w_out;
    logic               s_w_valid_out, r_w_valid_out;
    logic               s_w_swap_out, r_w_swap_out;
    logic               s_ovf, r_ovf;

    int total = 0;
    int bad   = 0;

    pe_ws_dbuf #(.ACT_W(8), .WGT_W(8), .ACC_W(32), .SAT_EN(1'b1)) dut_sat (
        .CLK(CLK), .RESET(RESET), .EN(EN),
        .act_in(act_in), .act_valid_in(act_valid_in),
        .act_out(s_act_out), .act_valid_out(s_act_valid_out),
        .psum_in(psum_in), .psum_out(s_psum_out), .psum_valid_out(s_psum_valid_out),
        .w_in(w_in), .w_valid_in(w_valid_in),
        .w_out(s_w_out), .w_valid_out(s_w_valid_out),
        .w_swap_in(w_swap_in), .w_swap_out(s_w_swap_out),
        .ovf(s_ovf)
    );

    pe_ws_dbuf #(.ACT_W(8), .WGT_W(8), .ACC_W(32), .SAT_EN(1'b0)) dut_wrap (
        .CLK(CLK), .RESET(RESET), .EN(EN),
        .act_in(act_in), .act_valid_in(act_valid_in),
        .act_out(r_act_out), .act_valid_out(r_act_valid_out),
        .psum_in(psum_in), .psum_out(r_psum_out), .psum_valid_out(r_psum_valid_out),
        .w_in(w_in), .w_valid_in(w_valid_in),
        .w_out(r_w_out), .w_valid_out(r_w_valid_out),
        .w_swap_in(w_swap_in), .w_swap_out(r_w_swap_out),
        .ovf(r_ovf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic               wv;
        logic signed [7:0]  w;
        logic               sw;
        logic               av;
        logic signed [7:0]  act;
        logic signed [31:0] psum;
        logic signed [31:0] e_psum;
        logic               e_pv;
        logic signed [7:0]  e_wout;
        logic               e_wvo;
        logic               e_swo;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input int wv, input int w, input int sw, input int av,
                                input int act, input int psum, input int e_psum,
                                input int e_pv, input int e_wout, input int e_wvo,
                                input int e_swo);
        vec_t v;
        v.wv = wv[0]; v.w = w[7:0]; v.sw = sw[0]; v.av = av[0];
        v.act = act[7:0]; v.psum = psum; v.e_psum = e_psum; v.e_pv = e_pv[0];
        v.e_wout = e_wout[7:0]; v.e_wvo = e_wvo[0]; v.e_swo = e_swo[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic drive(input logic wv, input logic signed [7:0] w, input logic sw,
                         input logic av, input logic signed [7:0] act,
                         input logic signed [31:0] psum);
        w_valid_in = wv; w_in = w; w_swap_in = sw;
        act_valid_in = av; act_in = act; psum_in = psum;
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " act_out"}, s_act_out, 0);
        chk({tag, " act_valid_out"}, s_act_valid_out, 0);
        chk({tag, " psum_out"}, s_psum_out, 0);
        chk({tag, " psum_valid_out"}, s_psum_valid_out, 0);
        chk({tag, " w_out"}, s_w_out, 0);
        chk({tag, " w_valid_out"}, s_w_valid_out, 0);
        chk({tag, " w_swap_out"}, s_w_swap_out, 0);
        chk({tag, " ovf"}, s_ovf, 0);
        chk({tag, " wrap psum_out"}, r_psum_out, 0);
        chk({tag, " wrap ovf"}, r_ovf, 0);
        chk({tag, " active_vld"}, dut_sat.u_wbuf.active_vld_reg, 0);
        chk({tag, " shadow_vld"}, dut_sat.u_wbuf.shadow_vld_reg, 0);
    endtask

    logic signed [31:0] c_pos_in, c_neg_in, c_max, c_min, c_wrap_pos, c_wrap_neg;

    initial begin
        c_pos_in   = 32'h7FFFFFF0;
        c_neg_in   = 32'h80000000;
        c_max      = 32'h7FFFFFFF;
        c_min      = 32'h80000000;
        c_wrap_pos = 32'h80003EF1;
        c_wrap_neg = 32'h7FFFC080;

        //          wv  w  sw av act psum | e_psum pv wout wvo swo
        vecs[0]  = mk(1, 5, 0, 0, 0, 0,     0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 7, 0, 0, 0, 0,     0, 0, 5, 1, 0);
        vecs[2]  = mk(0, 0, 1, 0, 0, 0,     0, 0, 5, 0, 1);
        vecs[3]  = mk(0, 0, 0, 1, 3, 10,    31, 1, 5, 0, 0);
        vecs[4]  = mk(1, 4, 0, 1, 2, 0,     14, 1, 7, 0, 0);
        vecs[5]  = mk(0, 0, 0, 1, 2, 0,     14, 1, 7, 0, 0);
        vecs[6]  = mk(0, 0, 1, 1, 2, 0,     14, 1, 7, 0, 1);
        vecs[7]  = mk(0, 0, 0, 1, 2, 0,     8, 1, 7, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 999,   8, 0, 7, 0, 0);
        vecs[9]  = mk(0, 0, 1, 0, 0, 0,     8, 0, 7, 0, 1);
        vecs[10] = mk(0, 0, 0, 1, -3, 100,  88, 1, 7, 0, 0);
        vecs[11] = mk(1, 9, 0, 0, 0, 0,     88, 0, 4, 0, 0);
        vecs[12] = mk(1, -2, 1, 1, 1, 0,    4, 1, 9, 1, 1);
        vecs[13] = mk(0, 0, 0, 1, 2, 1,     19, 1, 9, 0, 0);
        vecs[14] = mk(0, 0, 1, 0, 0, 0,     19, 0, 9, 0, 1);
        vecs[15] = mk(0, 0, 0, 1, 5, 0,     -10, 1, 9, 0, 0);

        // Reset state before any clock edge.
        RESET = 1'b0; EN = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk_all_zero("reset0");
        #1;
        RESET = 1'b1;

        // Table: load, commit, concurrent load/compute, collisions.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].wv, vecs[i].w, vecs[i].sw, vecs[i].av, vecs[i].act, vecs[i].psum);
            step();
            chk($sformatf("v%0d psum_out", i), s_psum_out, vecs[i].e_psum);
            chk($sformatf("v%0d wrap psum_out", i), r_psum_out, vecs[i].e_psum);
            chk($sformatf("v%0d psum_valid_out", i), s_psum_valid_out, vecs[i].e_pv);
            chk($sformatf("v%0d w_out", i), s_w_out, vecs[i].e_wout);
            chk($sformatf("v%0d w_valid_out", i), s_w_valid_out, vecs[i].e_wvo);
            chk($sformatf("v%0d w_swap_out", i), s_w_swap_out, vecs[i].e_swo);
            chk($sformatf("v%0d act_out", i), s_act_out, vecs[i].act);
            chk($sformatf("v%0d act_valid_out", i), s_act_valid_out, vecs[i].av);
            chk($sformatf("v%0d ovf", i), s_ovf, 0);
            $display("vec %0d: psum_out=%0d w_out=%0d w_valid_out=%0b w_swap_out=%0b",
                     i, s_psum_out, s_w_out, s_w_valid_out, s_w_swap_out);
        end

        // Saturation: load 127, commit, then overflow both directions.
        drive(1, 127, 0, 0, 0, 0); step();
        chk("sat load w_out", s_w_out, -2);
        drive(0, 0, 1, 0, 0, 0); step();
        drive(0, 0, 0, 1, 127, c_pos_in); step();
        chk("sat pos psum", s_psum_out, c_max);
        chk("sat pos ovf", s_ovf, 1);
        chk("wrap pos psum", r_psum_out, c_wrap_pos);
        chk("wrap pos ovf", r_ovf, 1);
        $display("sat pos: sat=%0h wrap=%0h", s_psum_out, r_psum_out);
        drive(0, 0, 0, 1, -128, c_neg_in); step();
        chk("sat neg psum", s_psum_out, c_min);
        chk("wrap neg psum", r_psum_out, c_wrap_neg);
        $display("sat neg: sat=%0h wrap=%0h", s_psum_out, r_psum_out);
        drive(0, 0, 0, 1, 1, 0); step();
        chk("post sat psum", s_psum_out, 127);
        chk("sticky ovf sat", s_ovf, 1);
        chk("sticky ovf wrap", r_ovf, 1);
        $display("sticky: psum=%0d ovf=%0b/%0b", s_psum_out, s_ovf, r_ovf);

        // Fill shadow with 3, then hold EN low with every input active.
        drive(1, 3, 0, 0, 0, 0); step();
        chk("pre-hold w_out", s_w_out, 127);
        chk("pre-hold w_valid_out", s_w_valid_out, 0);
        EN = 1'b0;
        drive(1, 50, 1, 1, 9, 77);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("hold%0d psum_out", c), s_psum_out, 127);
            chk($sformatf("hold%0d psum_valid_out", c), s_psum_valid_out, 0);
            chk($sformatf("hold%0d act_out", c), s_act_out, 0);
            chk($sformatf("hold%0d w_out", c), s_w_out, 127);
            chk($sformatf("hold%0d w_valid_out", c), s_w_valid_out, 0);
            chk($sformatf("hold%0d w_swap_out", c), s_w_swap_out, 0);
            $display("hold %0d: psum_out=%0d w_out=%0d", c, s_psum_out, s_w_out);
        end
        EN = 1'b1;
        // Swap during hold must have been ignored: active still 127.
        drive(0, 0, 0, 1, 1, 0); step();
        chk("after hold active", s_psum_out, 127);
        // Shadow must still be 3, not the 50 driven during hold.
        drive(0, 0, 1, 0, 0, 0); step();
        chk("after hold swap_out", s_w_swap_out, 1);
        drive(0, 0, 0, 1, 1, 0); step();
        chk("after hold shadow", s_psum_out, 3);
        $display("post hold: psum_out=%0d", s_psum_out);

        // Asynchronous reset mid-load and mid-compute.
        drive(1, 6, 0, 1, 1, 0); step();
        chk("pre-reset psum", s_psum_out, 3);
        #2;
        RESET = 1'b0;
        #1;
        chk_all_zero("midreset");
        $display("mid-stream reset: psum_out=%0d ovf=%0b", s_psum_out, s_ovf);
        @(negedge CLK);
        RESET = 1'b1;
        // No weight survives: the product term is zero.
        drive(0, 0, 0, 1, 1, 5); step();
        chk("post-reset passthrough", s_psum_out, 5);
        chk("post-reset ovf", s_ovf, 0);
        $display("post reset: psum_out=%0d", s_psum_out);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
